// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and counter sizing for the serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit counter width: $clog2(width+1), never narrower than one bit
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/done handshake and operand/result bus of the serial adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Controller side: issues requests, observes status and result
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  // Adder side: accepts requests, returns status and result
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - combinational 1-bit full adder built from two half-add stages
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  // First half-add stage: operand bits
  assign hs1 = x ^ y;
  assign hc1 = x & y;

  // Second half-add stage folds in the carry; either stage may generate the carry-out
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with start/busy/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_s;
  logic             fa_co;

  serial_fa_cell u_fa (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Accumulator shifts right with the new sum bit entering at the MSB
  always_comb begin
    acc_d            = acc_q >> 1;
    acc_d[WIDTH-1]   = fa_s;
  end

  // Control FSM plus datapath registers; outputs are registered here too
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a new start just like IDLE so back-to-back runs have no gap
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          carry_q <= fa_co;
          acc_q   <= acc_d;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          if (cnt_q == LAST_CNT) begin
            // Last bit: publish the result directly from the cell outputs
            cnt_q   <= '0;
            sum_q   <= acc_d;
            cout_q  <= fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances)
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] prev8;  // last completed {cout,sum} of the 8-bit instance

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    step();
    step();
    n_checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset8 busy=%b done=%b cout=%b sum=%h expected all zero", bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    n_checks++;
    if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset1 busy=%b done=%b cout=%b sum=%b expected all zero", bus1.busy, bus1.done, bus1.cout, bus1.sum);
    end
    rst = 1'b0;
    prev8 = 9'd0;
    step();
  endtask

  // One full 8-bit addition checked cycle by cycle against the arithmetic model
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input string tag);
    logic [8:0] expv;
    expv = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    step();
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    for (int k = 1; k <= 9; k++) begin
      n_checks++;
      if (bus8.busy !== (k <= 8) || bus8.done !== (k == 9)) begin
        n_fail++;
        $display("FAIL %s handshake cycle T+%0d busy=%b done=%b expected busy=%b done=%b",
                 tag, k, bus8.busy, bus8.done, (k <= 8), (k == 9));
      end
      if (k < 9) begin
        n_checks++;
        if ({bus8.cout, bus8.sum} !== prev8) begin
          n_fail++;
          $display("FAIL %s held cycle T+%0d result=%h expected %h", tag, k, {bus8.cout, bus8.sum}, prev8);
        end
        step();
      end
    end
    n_checks++;
    if ({bus8.cout, bus8.sum} !== expv) begin
      n_fail++;
      $display("FAIL %s result cout=%b sum=%h expected cout=%b sum=%h", tag, bus8.cout, bus8.sum, expv[8], expv[7:0]);
    end
    prev8 = expv;
    step();
  endtask

  task automatic test_directed();
    run8(8'h5A, 8'h33, 1'b0, "add_5a_33");
    run8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
    run8(8'h00, 8'h00, 1'b0, "add_zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_ignore_start();
    int n_done;
    int done_at;
    n_done = 0;
    done_at = -1;
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0;
    step();                                  // T+1
    bus8.start = 1'b0;
    step();
    step();                                  // T+3
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b1;
    for (int k = 3; k <= 20; k++) begin
      if (bus8.done === 1'b1) begin
        n_done++;
        done_at = k;
        n_checks++;
        if ({bus8.cout, bus8.sum} !== 9'h030) begin
          n_fail++;
          $display("FAIL ignore_start result=%h expected 030", {bus8.cout, bus8.sum});
        end
      end
      step();
      bus8.start = 1'b0;
    end
    n_checks++;
    if (n_done != 1 || done_at != 9) begin
      n_fail++;
      $display("FAIL ignore_start done_count=%0d at T+%0d expected 1 at T+9", n_done, done_at);
    end
    prev8 = 9'h030;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1;
    logic [7:0] b1;
    logic [8:0] first;
    a1 = 8'($urandom); b1 = 8'($urandom);
    first = {1'b0, a1} + {1'b0, b1};
    bus8.start = 1'b1; bus8.a = a1; bus8.b = b1; bus8.cin = 1'b0;
    step();                                  // T+1
    bus8.start = 1'b0;
    for (int k = 2; k <= 8; k++) step();     // T+8
    bus8.start = 1'b1; bus8.a = 8'h0F; bus8.b = 8'hF1; bus8.cin = 1'b0;
    step();                                  // T+9: DONE with start high
    n_checks++;
    if (bus8.done !== 1'b1 || {bus8.cout, bus8.sum} !== first) begin
      n_fail++;
      $display("FAIL b2b first done=%b result=%h expected done=1 result=%h", bus8.done, {bus8.cout, bus8.sum}, first);
    end
    step();                                  // T+10
    bus8.start = 1'b0;
    for (int k = 10; k <= 18; k++) begin
      n_checks++;
      if (bus8.busy !== (k <= 17) || bus8.done !== (k == 18)) begin
        n_fail++;
        $display("FAIL b2b handshake cycle T+%0d busy=%b done=%b expected busy=%b done=%b",
                 k, bus8.busy, bus8.done, (k <= 17), (k == 18));
      end
      n_checks++;
      if (k < 18 && {bus8.cout, bus8.sum} !== first) begin
        n_fail++;
        $display("FAIL b2b held cycle T+%0d result=%h expected %h", k, {bus8.cout, bus8.sum}, first);
      end else if (k == 18 && {bus8.cout, bus8.sum} !== 9'h100) begin
        n_fail++;
        $display("FAIL b2b second result=%h expected 100", {bus8.cout, bus8.sum});
      end
      if (k < 18) step();
    end
    prev8 = 9'h100;
    step();
  endtask

  task automatic test_reset_mid_run();
    int n_done;
    n_done = 0;
    bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h5E; bus8.cin = 1'b1;
    step();                                  // T+1
    bus8.start = 1'b0;
    step();
    step();
    step();                                  // T+4
    rst = 1'b1;
    step();                                  // T+5
    n_checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_reset busy=%b done=%b cout=%b sum=%h expected all zero", bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    rst = 1'b0;
    prev8 = 9'd0;
    for (int k = 0; k < 12; k++) begin
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) n_done++;
      step();
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet activity_cycles=%0d expected 0", n_done);
    end
    run8(8'h81, 8'h7F, 1'b0, "after_reset");
  endtask

  task automatic test_width1();
    logic [1:0] expv;
    for (int i = 0; i < 8; i++) begin
      expv = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      bus1.start = 1'b1; bus1.a = i[2]; bus1.b = i[1]; bus1.cin = i[0];
      step();                                // T+1
      bus1.start = 1'b0; bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.cin = 1'($urandom);
      n_checks++;
      if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
        n_fail++;
        $display("FAIL w1 run combo=%0d busy=%b done=%b expected busy=1 done=0", i, bus1.busy, bus1.done);
      end
      step();                                // T+2
      n_checks++;
      if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || {bus1.cout, bus1.sum} !== expv) begin
        n_fail++;
        $display("FAIL w1 done combo=%0d done=%b busy=%b result=%b expected done=1 busy=0 result=%b",
                 i, bus1.done, bus1.busy, {bus1.cout, bus1.sum}, expv);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
